// File: rtl/i2c_target_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_pkg
// Brief    : Shared constants for the I2C target register file.
// Revision : 1.0
// ============================================================================
package i2c_target_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_SUB       = 4'd3;
    localparam logic [3:0] ST_SUB_ACK   = 4'd4;
    localparam logic [3:0] ST_WR        = 4'd5;
    localparam logic [3:0] ST_WR_ACK    = 4'd6;
    localparam logic [3:0] ST_RD        = 4'd7;
    localparam logic [3:0] ST_RD_ACK    = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [7:0] OOR_READ_DATA = 8'hFF;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_target_regfile_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sampler
// Brief    : SCL/SDA synchronizer and bus event detector. Defining
//            I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Revision : 1.0
// ============================================================================
module i2c_bus_sampler
    import i2c_target_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_c;
    logic       sda_c;
    logic       scl_p;
    logic       sda_p;

    // Idle bus is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    assign scl_c = majority3(scl_sync[1], scl_hist[0], scl_hist[1]);
    assign sda_c = majority3(sda_sync[1], sda_hist[0], sda_hist[1]);
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_c;
            sda_p <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_p;
    assign scl_fall  = ~scl_c & scl_p;
    assign start_det = scl_c & scl_p & sda_p & ~sda_c;
    assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;
    assign sda_s     = sda_c;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Brief    : I2C target with auto-incrementing 8-bit register file and a
//            local host port. Optional I2C_TARGET_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h1E,
    parameter int         REG_AW      = 5
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              i2c_wr_pulse,
    output logic [6:0]        i2c_wr_addr,
    output logic [7:0]        i2c_wr_data,
    output logic              busy,
    output logic [3:0]        state_dbg
);

    localparam int NREGS = 2 ** REG_AW;

    logic [7:0] regs [NREGS];
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [6:0] tx;
    logic [6:0] ptr;
    logic       auto_inc;
    logic       rd_mode;
    logic       mst_ack;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_s;

    logic       ptr_ok;
    logic [7:0] rd_byte;
    logic [7:0] wr_byte;
    logic [6:0] ptr_next;

    i2c_bus_sampler u_sampler (
        .clk       (sys_clk),
        .rst       (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign ptr_ok     = ({25'd0, ptr} < 32'(NREGS));
    assign rd_byte    = ptr_ok ? regs[ptr[REG_AW-1:0]] : OOR_READ_DATA;
    assign wr_byte    = {shreg[6:0], sda_s};
    assign ptr_next   = auto_inc ? ptr + 7'd1 : ptr;
    assign host_rdata = regs[host_addr];
    assign state_dbg  = state;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 8'h00;
            tx           <= 7'h00;
            ptr          <= 7'h00;
            auto_inc     <= 1'b0;
            rd_mode      <= 1'b0;
            mst_ack      <= 1'b0;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            i2c_wr_pulse <= 1'b0;
            i2c_wr_addr  <= 7'h00;
            i2c_wr_data  <= 8'h00;
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
            i2c_wr_pulse <= 1'b0;
            // Host write first so a same-cycle I2C write to that register wins.
            if (host_we) regs[host_addr] <= host_wdata;

            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_WR: begin
                        if (scl_rise) begin
                            shreg   <= wr_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == ST_WR && bit_cnt == 4'd7) begin
                                if (ptr_ok) begin
                                    regs[ptr[REG_AW-1:0]] <= wr_byte;
                                    i2c_wr_pulse          <= 1'b1;
                                    i2c_wr_addr           <= ptr;
                                    i2c_wr_data           <= wr_byte;
                                end
                                ptr <= ptr_next;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            case (state)
                                ST_ADDR: begin
                                    if (shreg[7:1] == TARGET_ADDR) begin
                                        state   <= ST_ADDR_ACK;
                                        sda_oe  <= 1'b1;
                                        busy    <= 1'b1;
                                        rd_mode <= shreg[0];
                                    end else begin
                                        state <= ST_WAIT_STOP;
                                        busy  <= 1'b0;
                                    end
                                end
                                ST_SUB: begin
                                    auto_inc <= shreg[7];
                                    ptr      <= shreg[6:0];
                                    state    <= ST_SUB_ACK;
                                    sda_oe   <= 1'b1;
                                end
                                default: begin
                                    state  <= ST_WR_ACK;
                                    sda_oe <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_ADDR_ACK, ST_SUB_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR_ACK && rd_mode) begin
                                state  <= ST_RD;
                                tx     <= rd_byte[6:0];
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_ADDR_ACK) ? ST_SUB : ST_WR;
                            end
                        end
                    end
                    ST_RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state  <= ST_RD_ACK;
                                sda_oe <= 1'b0;
                                ptr    <= ptr_next;
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[5:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            mst_ack <= sda_s;
                        end else if (scl_fall) begin
                            if (mst_ack == NACK) begin
                                state <= ST_WAIT_STOP;
                            end else begin
                                state   <= ST_RD;
                                bit_cnt <= 4'd0;
                                tx      <= rd_byte[6:0];
                                sda_oe  <= ~rd_byte[7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
